// File: rtl/shift_req_pkg.sv
// Shared constants and the queued shift-request record for the shift request FIFO.
package shift_req_pkg;

    localparam int DEF_N     = 8;
    localparam int DEF_SW    = 3;
    localparam int DEF_DEPTH = 4;

    typedef struct packed {
        logic [DEF_N-1:0]  data;
        logic [DEF_SW-1:0] shamt;
        logic              ovf;
    } shift_req_t;

endpackage

// File: rtl/shift_ovf_check.sv
// Combinational overflow check: flags a left shift that would push nonzero bits out of N.
module shift_ovf_check #(
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic [N-1:0]  data,
    input  logic [SW-1:0] shamt,
    output logic          ovf
);

    logic [31:0] w_rsh;

    // The bits that fall off the top are exactly data >> (N - shamt).
    assign w_rsh = 32'(N) - 32'(shamt);
    assign ovf   = (shamt != '0) && ((data >> w_rsh) != '0);

endmodule

// File: rtl/shift_req_fifo.sv
// First-word fall-through FIFO of shift requests; overflow is evaluated once on the write path.
module shift_req_fifo
    import shift_req_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int N     = DEF_N,
    parameter int SW    = DEF_SW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_data,
    input  logic [SW-1:0]              in_shamt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_data,
    output logic [SW-1:0]              out_shamt,
    output logic                       out_ovf,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    shift_req_t    r_mem [DEPTH];

    logic       w_push;
    logic       w_pop;
    logic       w_ovf;
    shift_req_t w_entry;
    shift_req_t w_head;

    shift_ovf_check #(
        .N  (N),
        .SW (SW)
    ) u_ovf_check (
        .data  (in_data),
        .shamt (in_shamt),
        .ovf   (w_ovf)
    );

    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign w_entry.data  = in_data;
    assign w_entry.shamt = in_shamt;
    assign w_entry.ovf   = w_ovf;

    // Outputs read only registered storage, so a push is visible one cycle later at the earliest.
    assign w_head    = r_mem[r_rd_ptr];
    assign out_data  = out_valid ? w_head.data  : '0;
    assign out_shamt = out_valid ? w_head.shamt : '0;
    assign out_ovf   = out_valid ? w_head.ovf   : 1'b0;
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/shift_req_fifo.md
SHIFT_REQ_FIFO -- requirements
Module: shift_req_fifo

Interface
REQ-001 Parameter DEPTH, default 4: number of queued shift requests; power of two, at least 2.
REQ-002 Parameter N, default 8: data width in bits.
REQ-003 Parameter SW, default 3: shift-amount width, equal to ceiling log2 of N.
REQ-004 clk  input  1: sole clock; all state updates on its rising edge.
REQ-005 rst  input  1: reset, synchronous, active-high.
REQ-006 in_valid  input  1: upstream request present.
REQ-007 in_ready  output  1: FIFO can accept a request this cycle.
REQ-008 in_data  input  N: operand to be shifted left.
REQ-009 in_shamt  input  SW: shift amount, 0 to N-1.
REQ-010 out_valid  output  1: head request available to the downstream barrel shifter.
REQ-011 out_ready  input  1: downstream shifter consumes the head this cycle.
REQ-012 out_data  output  N: head operand.
REQ-013 out_shamt  output  SW: head shift amount.
REQ-014 out_ovf  output  1: head request loses nonzero bits when shifted (multiply overflow).
REQ-015 count  output  clog2(DEPTH+1): number of occupied entries.

Function
REQ-016 Push occurs when in_valid and in_ready are both high; pop occurs when out_valid and out_ready are both high.
REQ-017 in_ready is high when count is less than DEPTH, is driven from registered state only, and never depends on out_ready.
REQ-018 out_valid is high when count is nonzero; out_data, out_shamt and out_ovf present the oldest entry (first-word fall-through).
REQ-019 A request pushed in cycle T appears at the outputs no earlier than cycle T+1; there is no combinational path from in_* to out_*.
REQ-020 ovf is computed at push: ovf is 1 when (in_data >> (N - in_shamt)) is nonzero and in_shamt is nonzero; ovf is 0 when in_shamt is 0. It is stored with the entry.
REQ-021 Push and pop in the same cycle leave count unchanged and update both pointers.
REQ-022 When empty, a push with out_ready high is not popped in the same cycle; out_valid rises in the next cycle.
REQ-023 When full, in_ready is low even if out_ready is high; a concurrent in_valid is ignored.
REQ-024 Read and write pointers wrap modulo DEPTH without gaps.
REQ-025 When out_valid is high and out_ready is low, out_data, out_shamt and out_ovf hold stable.
REQ-026 Outputs are undefined-free: when empty, out_data, out_shamt and out_ovf drive 0.

Reset
REQ-027 While rst is high at a clock edge: pointers and count become 0, out_valid becomes 0, in_ready becomes 1, and out_data, out_shamt and out_ovf become 0.
REQ-028 Reset asserted during operation discards all queued entries; pushes and pops in that cycle are ignored.
REQ-029 Storage array contents need not be reset.

Structure
REQ-030 Package shift_req_pkg holds the constants N, SW and DEPTH defaults and the packed struct shift_req_t containing data, shamt and ovf.
REQ-031 The overflow check is implemented as the combinational sub-module shift_ovf_check, with inputs data and shamt and output ovf; the FIFO instantiates it on the write path.
REQ-032 Storage is a register array of shift_req_t; the design uses no vendor macros.

Verification
REQ-033 Reset, then push 0x81 with shamt 1 -> after 1 cycle: out_valid=1, out_data=0x81, out_shamt=1, out_ovf=1, count=1.
REQ-034 Push 0x0F with shamt 4, then 0x10 with shamt 4, with out_ready low -> ovf values 0 then 1; count=2; head stable for 3 idle cycles.
REQ-035 Push 4 requests (0x01 to 0x04) with out_ready low -> in_ready=0, count=4; a fifth push of 0x05 is ignored; draining yields 0x01 to 0x04 in order.
REQ-036 With count=2, hold in_valid and out_ready high for 10 cycles with incrementing data -> count stays 2, outputs arrive in order, and the pointers wrap correctly.
REQ-037 With count=3, assert rst for 1 cycle alongside in_valid -> count=0, out_valid=0, in_ready=1 on the next cycle, and the in-flight push is lost.
REQ-038 Push 0xFF with shamt 0 -> out_ovf=0; push 0x01 with shamt 7 -> out_ovf=0; push 0x02 with shamt 7 -> out_ovf=1.
